// File: rtl/if_ctrl_pkg.sv
// Shared types and constants for the IF-stage fetch sequencer.
// Imported by the fetch controller and its memory interface.
package if_ctrl_pkg;

   typedef enum logic [2:0] {
      BOOT,
      REQ,
      DRAIN,
      STALL,
      ERR
   } state_t;

   localparam int unsigned DEF_TIMEOUT = 15;
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/ready handshake bundle.
// The controller is master; the memory is slave.
interface if_fetch_ctrl_if;
   import if_ctrl_pkg::*;

   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ready
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous
// active-low clear.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         en,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (!clr_n)
         count <= '0;
      else if (en && (count != '1))
         count <= count + ONE;
   end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: memory handshake, freeze,
// branch redirect, IF/ID valid/flush and timeout detection.
module if_fetch_ctrl
   import if_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   hazard,
   input  logic                   branch_taken_in,
   input  logic [31:0]            branch_addr_in,
   input  logic [31:0]            pc_if,
   if_fetch_ctrl_if.master        mem,
   output logic                   if_freeze,
   output logic                   if_branch_taken,
   output logic [31:0]            if_branch_addr,
   output logic                   if_id_valid,
   output logic                   if_id_flush,
   output logic                   fetch_error,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam logic [7:0] TO = 8'(TIMEOUT);

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  wait_cnt;
   logic [7:0]  wait_nxt;
   logic [7:0]  wait_inc;
   logic [31:0] pend;
   logic [31:0] pend_nxt;
   logic        rdy;
   logic        br;
   logic        waiting;

   assign rdy      = mem.mem_ready;
   assign br       = branch_taken_in;
   assign wait_inc = wait_cnt + 8'd1;
   assign waiting  = mem.mem_req & ~rdy;
   assign mem.mem_addr = pc_if & WORD_MASK;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= BOOT;
         wait_cnt <= '0;
         pend     <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         pend     <= pend_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wait_nxt  = '0;
      pend_nxt  = pend;
      unique case (state)
         BOOT: state_nxt = REQ;
         REQ: begin
            if (br) begin
               if (!rdy) begin
                  pend_nxt  = branch_addr_in;
                  state_nxt = DRAIN;
               end
            end else if (rdy && hazard) begin
               state_nxt = STALL;
            end
         end
         DRAIN: begin
            if (br)
               pend_nxt = branch_addr_in;
            if (rdy)
               state_nxt = REQ;
         end
         STALL: begin
            if (br || !hazard)
               state_nxt = REQ;
         end
         ERR: state_nxt = ERR;
         default: state_nxt = BOOT;
      endcase
      // Waiting only accumulates while the state holds
      if (waiting && (state_nxt == state)) begin
         if (wait_inc == TO)
            state_nxt = ERR;
         else
            wait_nxt = wait_inc;
      end
   end

   always_comb begin
      mem.mem_req     = 1'b0;
      if_freeze       = 1'b1;
      if_branch_taken = 1'b0;
      if_branch_addr  = '0;
      if_id_valid     = 1'b0;
      if_id_flush     = 1'b0;
      fetch_error     = 1'b0;
      unique case (state)
         BOOT: ;
         REQ: begin
            mem.mem_req = 1'b1;
            if (br && rdy) begin
               if_branch_taken = 1'b1;
               if_branch_addr  = branch_addr_in;
               if_freeze       = 1'b0;
               if_id_flush     = 1'b1;
            end else if (!br && rdy && !hazard) begin
               if_freeze   = 1'b0;
               if_id_valid = 1'b1;
            end
         end
         DRAIN: begin
            mem.mem_req = 1'b1;
            if (rdy) begin
               if_branch_taken = 1'b1;
               if_branch_addr  = br ? branch_addr_in : pend;
               if_freeze       = 1'b0;
               if_id_flush     = 1'b1;
            end
         end
         STALL: begin
            if (br) begin
               if_branch_taken = 1'b1;
               if_branch_addr  = branch_addr_in;
               if_freeze       = 1'b0;
               if_id_flush     = 1'b1;
            end
         end
         ERR: fetch_error = 1'b1;
         default: ;
      endcase
   end

   sat_counter #(
      .W (STALL_CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .clr_n (reset),
      .en    (if_freeze && (state != ERR)),
      .count (stall_cycles)
   );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for the IF fetch sequencer with a
// small IF-stage PC model closing the loop.
module tb_if_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        hazard;
   logic        br;
   logic [31:0] baddr;
   logic [31:0] pc;
   logic        if_freeze;
   logic        if_branch_taken;
   logic [31:0] if_branch_addr;
   logic        if_id_valid;
   logic        if_id_flush;
   logic        fetch_error;
   logic [15:0] stall_cycles;
   int          checks = 0;
   int          failures = 0;

   if_fetch_ctrl_if mif ();

   if_fetch_ctrl #(
      .TIMEOUT     (15),
      .STALL_CNT_W (16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .hazard          (hazard),
      .branch_taken_in (br),
      .branch_addr_in  (baddr),
      .pc_if           (pc),
      .mem             (mif.master),
      .if_freeze       (if_freeze),
      .if_branch_taken (if_branch_taken),
      .if_branch_addr  (if_branch_addr),
      .if_id_valid     (if_id_valid),
      .if_id_flush     (if_id_flush),
      .fetch_error     (fetch_error),
      .stall_cycles    (stall_cycles)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!reset)
         pc <= 32'h0;
      else if (!if_freeze)
         pc <= if_branch_taken ? if_branch_addr : pc + 32'd4;
   end

   task automatic test_reset;
      reset = 1'b0; hazard = 1'b0; br = 1'b0;
      baddr = 32'h0; mif.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      checks++; if (mif.mem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", mif.mem_req); end
      checks++; if (if_freeze !== 1'b1) begin failures++; $display("FAIL rst_freeze got=%b exp=1", if_freeze); end
      checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", stall_cycles); end
      checks++; if (fetch_error !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", fetch_error); end
      checks++; if ({if_id_valid, if_id_flush, if_branch_taken} !== 3'b000) begin failures++; $display("FAIL rst_ctl got=%b exp=000", {if_id_valid, if_id_flush, if_branch_taken}); end
   endtask

   task automatic test_stream;
      reset = 1'b1; mif.mem_ready = 1'b1; #1;
      checks++; if (mif.mem_req !== 1'b0 || if_freeze !== 1'b1) begin failures++; $display("FAIL boot req/frz got=%b%b exp=01", mif.mem_req, if_freeze); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         checks++; if (if_id_valid !== 1'b1 || if_freeze !== 1'b0) begin failures++; $display("FAIL stream_valid[%0d] got=%b%b exp=10", i, if_id_valid, if_freeze); end
         checks++; if (mif.mem_addr !== 32'(4 * i)) begin failures++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, mif.mem_addr, 4 * i); end
      end
      checks++; if (stall_cycles !== 16'd1) begin failures++; $display("FAIL stream_stall got=%0d exp=1", stall_cycles); end
   endtask

   task automatic test_wait;
      for (int f = 0; f < 2; f++) begin
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mif.mem_ready = (c == 2); #1;
            checks++; if (if_freeze !== (c != 2) || if_id_valid !== (c == 2)) begin failures++; $display("FAIL wait_frz_vld[%0d.%0d] got=%b%b exp=%b%b", f, c, if_freeze, if_id_valid, c != 2, c == 2); end
            checks++; if (mif.mem_addr !== 32'(16 + 4 * f) || mif.mem_req !== 1'b1) begin failures++; $display("FAIL wait_addr[%0d.%0d] got=%h exp=%h", f, c, mif.mem_addr, 16 + 4 * f); end
            checks++; if (stall_cycles !== 16'(1 + 2 * f + c)) begin failures++; $display("FAIL wait_stall[%0d.%0d] got=%0d exp=%0d", f, c, stall_cycles, 1 + 2 * f + c); end
         end
      end
   endtask

   task automatic test_drain;
      @(negedge clk);
      mif.mem_ready = 1'b0; br = 1'b1; baddr = 32'h100; #1;
      checks++; if (if_freeze !== 1'b1 || if_branch_taken !== 1'b0 || mif.mem_addr !== 32'h18) begin failures++; $display("FAIL drain_enter got=%b%b %h exp=10 18", if_freeze, if_branch_taken, mif.mem_addr); end
      @(negedge clk);
      baddr = 32'h200; #1;
      checks++; if (mif.mem_req !== 1'b1 || if_freeze !== 1'b1) begin failures++; $display("FAIL drain_hold got=%b%b exp=11", mif.mem_req, if_freeze); end
      @(negedge clk);
      br = 1'b0; baddr = 32'h0; mif.mem_ready = 1'b1; #1;
      checks++; if (if_branch_taken !== 1'b1 || if_branch_addr !== 32'h200) begin failures++; $display("FAIL drain_redirect got=%b %h exp=1 200", if_branch_taken, if_branch_addr); end
      checks++; if (if_id_flush !== 1'b1 || if_id_valid !== 1'b0 || if_freeze !== 1'b0) begin failures++; $display("FAIL drain_flush got=%b%b%b exp=100", if_id_flush, if_id_valid, if_freeze); end
      @(negedge clk); #1;
      checks++; if (mif.mem_addr !== 32'h200 || if_id_valid !== 1'b1) begin failures++; $display("FAIL drain_next got=%h %b exp=200 1", mif.mem_addr, if_id_valid); end
      checks++; if (stall_cycles !== 16'd7) begin failures++; $display("FAIL drain_stall got=%0d exp=7", stall_cycles); end
   endtask

   task automatic test_hazard;
      @(negedge clk);
      hazard = 1'b1; #1;
      checks++; if (if_id_valid !== 1'b0 || if_freeze !== 1'b1 || mif.mem_addr !== 32'h204) begin failures++; $display("FAIL hz_discard got=%b%b %h exp=01 204", if_id_valid, if_freeze, mif.mem_addr); end
      @(negedge clk); #1;
      checks++; if (mif.mem_req !== 1'b0 || if_freeze !== 1'b1) begin failures++; $display("FAIL hz_stall1 got=%b%b exp=01", mif.mem_req, if_freeze); end
      @(negedge clk);
      hazard = 1'b0; #1;
      checks++; if (mif.mem_req !== 1'b0 || if_freeze !== 1'b1) begin failures++; $display("FAIL hz_stall2 got=%b%b exp=01", mif.mem_req, if_freeze); end
      @(negedge clk); #1;
      checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h204 || if_id_valid !== 1'b1) begin failures++; $display("FAIL hz_refetch got=%b %h %b exp=1 204 1", mif.mem_req, mif.mem_addr, if_id_valid); end
      @(negedge clk);
      hazard = 1'b1; #1;
      @(negedge clk);
      br = 1'b1; baddr = 32'h300; #1;
      checks++; if (if_branch_taken !== 1'b1 || if_freeze !== 1'b0 || if_id_flush !== 1'b1 || mif.mem_req !== 1'b0) begin failures++; $display("FAIL hz_branch got=%b%b%b%b exp=1010", if_branch_taken, if_freeze, if_id_flush, mif.mem_req); end
      checks++; if (if_branch_addr !== 32'h300) begin failures++; $display("FAIL hz_baddr got=%h exp=300", if_branch_addr); end
      @(negedge clk);
      br = 1'b0; baddr = 32'h0; hazard = 1'b0; #1;
      checks++; if (mif.mem_addr !== 32'h300 || if_id_valid !== 1'b1) begin failures++; $display("FAIL hz_target got=%h %b exp=300 1", mif.mem_addr, if_id_valid); end
      checks++; if (stall_cycles !== 16'd11) begin failures++; $display("FAIL hz_stall_cnt got=%0d exp=11", stall_cycles); end
   endtask

   task automatic test_timeout;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         mif.mem_ready = 1'b0; #1;
         checks++; if (mif.mem_req !== 1'b1 || fetch_error !== 1'b0) begin failures++; $display("FAIL to_wait[%0d] got=%b%b exp=10", k, mif.mem_req, fetch_error); end
      end
      @(negedge clk); #1;
      checks++; if (fetch_error !== 1'b1 || mif.mem_req !== 1'b0 || if_freeze !== 1'b1) begin failures++; $display("FAIL to_err got=%b%b%b exp=101", fetch_error, mif.mem_req, if_freeze); end
      checks++; if (stall_cycles !== 16'd26) begin failures++; $display("FAIL to_stall got=%0d exp=26", stall_cycles); end
      br = 1'b1; baddr = 32'h400; #1;
      checks++; if (if_branch_taken !== 1'b0 || if_freeze !== 1'b1) begin failures++; $display("FAIL to_br_ignored got=%b%b exp=01", if_branch_taken, if_freeze); end
      @(negedge clk);
      br = 1'b0; baddr = 32'h0; #1;
      checks++; if (fetch_error !== 1'b1 || mif.mem_addr !== 32'h304 || stall_cycles !== 16'd26) begin failures++; $display("FAIL to_sticky got=%b %h %0d exp=1 304 26", fetch_error, mif.mem_addr, stall_cycles); end
      reset = 1'b0;
      @(negedge clk); #1;
      checks++; if (fetch_error !== 1'b0 || stall_cycles !== 16'd0 || mif.mem_req !== 1'b0) begin failures++; $display("FAIL to_clear got=%b %0d %b exp=0 0 0", fetch_error, stall_cycles, mif.mem_req); end
      reset = 1'b1; mif.mem_ready = 1'b1;
      @(negedge clk); #1;
      checks++; if (if_id_valid !== 1'b1 || mif.mem_addr !== 32'h0) begin failures++; $display("FAIL to_restart got=%b %h exp=1 0", if_id_valid, mif.mem_addr); end
   endtask

   task automatic test_reset_midwait;
      @(negedge clk);
      mif.mem_ready = 1'b0; #1;
      checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h4) begin failures++; $display("FAIL mw_wait got=%b %h exp=1 4", mif.mem_req, mif.mem_addr); end
      @(negedge clk);
      reset = 1'b0; #1;
      @(negedge clk);
      reset = 1'b1; #1;
      checks++; if (mif.mem_req !== 1'b0 || if_freeze !== 1'b1 || stall_cycles !== 16'd0) begin failures++; $display("FAIL mw_boot got=%b%b %0d exp=01 0", mif.mem_req, if_freeze, stall_cycles); end
      @(negedge clk);
      mif.mem_ready = 1'b1; #1;
      checks++; if (if_id_valid !== 1'b1 || mif.mem_addr !== 32'h0 || stall_cycles !== 16'd1) begin failures++; $display("FAIL mw_refetch got=%b %h %0d exp=1 0 1", if_id_valid, mif.mem_addr, stall_cycles); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_wait();
      test_drain();
      test_hazard();
      test_timeout();
      test_reset_midwait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Sequencing controller for the ARM instruction-fetch stage when instruction memory has variable latency. It drives a req/ready handshake to memory and generates the IF-stage Freeze and Branch_Taken/Branch_Addres controls. It also generates IF/ID valid and flush, and holds late branch redirects while a fetch is outstanding. It sits between the hazard unit, the EXE branch resolution and the IF stage.

Parameters:
TIMEOUT, 15, maximum consecutive cycles waiting on mem_ready before entering the error state (valid range 1..255).
STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset.
hazard  input  1  hazard-unit stall request from ID.
branch_taken_in  input  1  one-cycle pulse from EXE: branch resolved taken.
branch_addr_in  input  32  branch target, valid with branch_taken_in.
pc_if  input  32  current IF PC register value.
mem_ready  input  1  instruction memory: data valid this cycle.
mem_req  output  1  fetch request to instruction memory.
mem_addr  output  32  fetch address = {pc_if[31:2],2'b00}.
if_freeze  output  1  IF-stage Freeze; PC holds when 1.
if_branch_taken  output  1  IF-stage Branch_Taken select.
if_branch_addr  output  32  IF-stage Branch_Addres.
if_id_valid  output  1  IF/ID latches a valid instruction this cycle.
if_id_flush  output  1  IF/ID inserts a bubble this cycle.
fetch_error  output  1  sticky fetch-timeout flag.
stall_cycles  output  STALL_CNT_W  saturating count of cycles with if_freeze=1.

Behaviour:
- Reset (reset=0 at edge): state=BOOT, wait counter=0, pending-branch register=0, stall_cycles=0, fetch_error=0.
- BOOT outputs: mem_req=0, if_freeze=1, if_branch_taken=0, if_id_valid=0, if_id_flush=0.
- BOOT lasts exactly one cycle, then goes to REQ.
- A reset while a fetch is outstanding aborts it. Memory must tolerate a dropped request.
- Completion = mem_req & mem_ready in the same cycle. mem_req stays high and mem_addr stays stable until completion, because PC is frozen while waiting.
- if_branch_addr = branch_addr_in when a redirect is applied directly, and the pending register when applied from DRAIN. It is 0 otherwise.
- REQ state, mem_req=1:
  - No completion and no branch: if_freeze=1, wait counter +1.
  - Completion, no hazard, no branch: if_freeze=0, if_id_valid=1, PC advances by 4. Stay in REQ.
  - Completion with hazard=1 and no branch: instruction is discarded (if_id_valid=0, if_freeze=1). Go to STALL. The same PC is refetched later.
  - Branch with completion in the same cycle: if_branch_taken=1, if_freeze=0, if_id_flush=1, if_id_valid=0. Stay in REQ.
  - Branch without completion: latch branch_addr_in into the pending register and go to DRAIN.
- DRAIN state, mem_req=1, if_freeze=1:
  - On completion: discard the data, if_branch_taken=1 with the pending address, if_freeze=0, if_id_flush=1. Go to REQ.
  - A further branch_taken_in while in DRAIN overwrites the pending register; the newest branch wins.
- STALL state: mem_req=0, if_freeze=1.
  - When hazard=0: go to REQ.
  - A branch in STALL is applied immediately: if_branch_taken=1, if_freeze=0, if_id_flush=1. Go to REQ.
- Priority: branch takes priority over hazard in every state, since the branch is older and flushes ID.
- Wait counter:
  - Counts cycles in REQ or DRAIN with mem_req & !mem_ready.
  - Clears on completion or on any state change.
  - When the counter reaches TIMEOUT, go to ERR.
- ERR state: mem_req=0, if_freeze=1, fetch_error=1, branches ignored. ERR is left only by reset.
- stall_cycles increments when if_freeze=1 and state≠ERR. It saturates at all-ones with no wrap.

Decomposition:
- Package if_ctrl_pkg holds:
  - the state enum: BOOT, REQ, DRAIN, STALL, ERR;
  - the default TIMEOUT;
  - the word-alignment mask constant.
- One sub-module, sat_counter (parameterised width, enable, synchronous active-low clear), used for stall_cycles.
- The wait counter stays inline.

Test Plan:
- Release reset, keep mem_ready=1 every cycle, pc_if tracks IF stage from 0. Required: one BOOT cycle, then if_id_valid=1 every cycle with mem_addr 0,4,8,C, and stall_cycles=1.
- Set mem_ready to arrive 3 cycles after each request. Required: if_freeze=1 for 2 cycles and 0 on the completion cycle; if_id_valid is a single pulse per fetch; stall_cycles grows by 2 per fetch.
- Pulse branch_taken_in with addr 0x100 on cycle 1 of a 3-cycle wait, then pulse again with 0x200 in DRAIN. Required: at completion, if_branch_taken=1, if_branch_addr=0x200, if_id_flush=1, if_id_valid=0; the next mem_addr is 0x200.
- Assert hazard at completion for 2 cycles. Required: if_id_valid=0, mem_req=0 for 2 cycles, then the same address is refetched; a branch during STALL redirects immediately with if_freeze=0.
- Hold mem_ready=0 with TIMEOUT=15. Required: after 15 waiting cycles, fetch_error=1 and mem_req=0; later branches are ignored; reset=0 clears the error and returns to BOOT.
- Pulse reset=0 mid-wait. Required: mem_req=0 and if_freeze=1 on the next cycle, stall_cycles=0, state BOOT.
